// File: rtl/vec_reduce_pkg.sv
// Shared types and the per-channel reduction helper for vec_reduce_pipe.
// Channel operands are zero-extended to MAX_WIDTH; only the low 'width' bits take part.
package vec_reduce_pkg;

  typedef enum logic [1:0] {
    RED_OR  = 2'd0,
    RED_AND = 2'd1,
    RED_XOR = 2'd2,
    RED_NOR = 2'd3
  } reduce_mode_t;

  localparam int unsigned MAX_WIDTH = 64;

  function automatic logic reduce_chan(input reduce_mode_t mode,
                                       input logic [MAX_WIDTH-1:0] operand,
                                       input int unsigned width);
    logic any_one;
    logic all_one;
    logic parity;
    logic result;
    any_one = 1'b0;
    all_one = 1'b1;
    parity  = 1'b0;
    result  = 1'b0;
    for (int unsigned i = 0; i < MAX_WIDTH; i++) begin
      if (i < width) begin
        any_one = any_one | operand[i];
        all_one = all_one & operand[i];
        parity  = parity ^ operand[i];
      end
    end
    case (mode)
      RED_OR:  result = any_one;
      RED_AND: result = all_one;
      RED_XOR: result = parity;
      RED_NOR: result = ~any_one;
      default: result = 1'b0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/vec_reduce_fifo.sv
// Result FIFO for vec_reduce_pipe: power-of-two depth, naturally wrapping pointers.
// rdata_o shows the head entry; it is only meaningful while empty_o is low.
module vec_reduce_fifo #(
  parameter int unsigned DW    = 4,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [DW-1:0]            wdata_i,
  output logic [DW-1:0]            rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);
  import vec_reduce_pkg::*;

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push_i) wr_d = wr_q + 1'b1;
    if (pop_i)  rd_d = rd_q + 1'b1;
    case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // NOTE: storage is deliberately not reset; the count gates visibility of every entry.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_q];
  assign count_o = cnt_q;
  assign full_o  = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/vec_reduce_pipe.sv
// Per-channel OR/AND/XOR/NOR reduction with results queued in an in-order FIFO.
// Accepted requests appear at the output one cycle later at the earliest.
module vec_reduce_pipe #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned NCHAN = 2,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               in_mode,
  input  logic [NCHAN*WIDTH-1:0]   in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NCHAN-1:0]         out_result,
  output logic [1:0]               out_mode,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [15:0]              accepted_cnt
);
  import vec_reduce_pkg::*;

  localparam int unsigned DW = NCHAN + 2;

  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [NCHAN-1:0] res_d;
  logic [DW-1:0]    head;
  logic [15:0]      acc_cnt_q;

  for (genvar c = 0; c < NCHAN; c++) begin : g_chan
    assign res_d[c] = reduce_chan(reduce_mode_t'(in_mode),
                                  MAX_WIDTH'(in_data[c*WIDTH +: WIDTH]), WIDTH);
  end

  // A full FIFO still accepts when the head leaves in the same cycle.
  assign pop      = out_valid && out_ready;
  assign in_ready = !rst && (!fifo_full || pop);
  assign push     = in_valid && in_ready;

  vec_reduce_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({in_mode, res_d}),
    .rdata_o (head),
    .count_o (occupancy),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_cnt_q <= '0;
    end else if (push && acc_cnt_q != 16'hFFFF) begin
      acc_cnt_q <= acc_cnt_q + 16'd1;
    end
  end

  assign out_valid    = !fifo_empty;
  assign out_result   = out_valid ? head[NCHAN-1:0] : '0;
  assign out_mode     = out_valid ? head[DW-1 -: 2] : 2'b00;
  assign accepted_cnt = acc_cnt_q;

endmodule

// File: tb/tb_vec_reduce_pipe.sv
// Directed self-checking bench for vec_reduce_pipe at default parameters.
// Inputs change 1 time unit after each rising edge; outputs are sampled there too.
module tb_vec_reduce_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_mode;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_result;
  logic [1:0] out_mode;
  logic [1:0] occupancy;
  logic [15:0] accepted_cnt;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  vec_reduce_pipe dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_mode      (in_mode),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_mode     (out_mode),
    .occupancy    (occupancy),
    .accepted_cnt (accepted_cnt)
  );

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] m, input logic [7:0] d);
    in_valid = v;
    in_mode  = m;
    in_data  = d;
  endtask

  task automatic test_reset;
    rst = 1'b1; out_ready = 1'b0; drive(1'b0, 2'd0, 8'h00);
    step(2);
    tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL rst_in_ready: got %b expected 0", in_ready); end
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
    tests_run++; if (occupancy !== 2'd0) begin tests_failed++; $display("FAIL rst_occupancy: got %0d expected 0", occupancy); end
    tests_run++; if (accepted_cnt !== 16'd0) begin tests_failed++; $display("FAIL rst_accepted: got %h expected 0000", accepted_cnt); end
    tests_run++; if ({out_result, out_mode} !== 4'b0000) begin tests_failed++; $display("FAIL rst_outputs: got %b/%b expected 00/00", out_result, out_mode); end
    rst = 1'b0;
    #1;
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_release_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_or;
    out_ready = 1'b1;
    drive(1'b1, 2'd0, 8'h20);
    #1;
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL or_no_comb_path: got %b expected 0", out_valid); end
    step();
    drive(1'b0, 2'd0, 8'h00);
    tests_run++; if ({out_valid, out_result, out_mode} !== 5'b1_10_00) begin tests_failed++; $display("FAIL or_result: got v=%b r=%b m=%0d expected v=1 r=10 m=0", out_valid, out_result, out_mode); end
    step();
    tests_run++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin tests_failed++; $display("FAIL or_drain: got v=%b occ=%0d expected v=0 occ=0", out_valid, occupancy); end
  endtask

  task automatic test_modes;
    logic [1:0] exp_res [3];
    exp_res[0] = 2'b10; exp_res[1] = 2'b01; exp_res[2] = 2'b00;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'(i + 1), 8'hF7);
      step();
      tests_run++; if ({out_valid, out_result, out_mode} !== {1'b1, exp_res[i], 2'(i + 1)}) begin tests_failed++; $display("FAIL modes_%0d: got v=%b r=%b m=%0d expected v=1 r=%b m=%0d", i + 1, out_valid, out_result, out_mode, exp_res[i], i + 1); end
    end
    drive(1'b0, 2'd0, 8'h00);
    step();
    tests_run++; if (occupancy !== 2'd0) begin tests_failed++; $display("FAIL modes_drain: got %0d expected 0", occupancy); end
  endtask

  task automatic test_back_to_back;
    out_ready = 1'b0;
    drive(1'b1, 2'd0, 8'h20);   // OR  -> 10
    step();
    drive(1'b1, 2'd2, 8'hF7);   // XOR -> 01
    step();
    drive(1'b1, 2'd3, 8'h00);   // NOR -> 11, held back
    tests_run++; if (in_ready !== 1'b0 || occupancy !== 2'd2) begin tests_failed++; $display("FAIL bp_full: got rdy=%b occ=%0d expected rdy=0 occ=2", in_ready, occupancy); end
    step(3);
    tests_run++; if (occupancy !== 2'd2 || out_result !== 2'b10 || out_mode !== 2'd0) begin tests_failed++; $display("FAIL bp_hold: got occ=%0d r=%b m=%0d expected occ=2 r=10 m=0", occupancy, out_result, out_mode); end
    out_ready = 1'b1;
    #1;
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_ready_with_pop: got %b expected 1", in_ready); end
    step();
    drive(1'b0, 2'd0, 8'h00);
    tests_run++; if (occupancy !== 2'd2 || out_result !== 2'b01 || out_mode !== 2'd2) begin tests_failed++; $display("FAIL bp_second: got occ=%0d r=%b m=%0d expected occ=2 r=01 m=2", occupancy, out_result, out_mode); end
    step();
    tests_run++; if (occupancy !== 2'd1 || out_result !== 2'b11 || out_mode !== 2'd3) begin tests_failed++; $display("FAIL bp_third: got occ=%0d r=%b m=%0d expected occ=1 r=11 m=3", occupancy, out_result, out_mode); end
    step();
    tests_run++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_drain: got occ=%0d v=%b expected occ=0 v=0", occupancy, out_valid); end
  endtask

  task automatic test_full_push_pop;
    out_ready = 1'b0;
    drive(1'b1, 2'd0, 8'h01);   // OR  -> 01
    step();
    drive(1'b1, 2'd1, 8'hFF);   // AND -> 11
    step();
    drive(1'b1, 2'd2, 8'h10);   // XOR -> 10
    out_ready = 1'b1;
    #1;
    tests_run++; if (in_ready !== 1'b1 || out_result !== 2'b01) begin tests_failed++; $display("FAIL full_pp_pre: got rdy=%b r=%b expected rdy=1 r=01", in_ready, out_result); end
    step();
    drive(1'b0, 2'd0, 8'h00);
    tests_run++; if (occupancy !== 2'd2 || out_result !== 2'b11 || out_mode !== 2'd1) begin tests_failed++; $display("FAIL full_pp_advance: got occ=%0d r=%b m=%0d expected occ=2 r=11 m=1", occupancy, out_result, out_mode); end
    step();
    tests_run++; if (occupancy !== 2'd1 || out_result !== 2'b10 || out_mode !== 2'd2) begin tests_failed++; $display("FAIL full_pp_new_entry: got occ=%0d r=%b m=%0d expected occ=1 r=10 m=2", occupancy, out_result, out_mode); end
    step();
    tests_run++; if (occupancy !== 2'd0) begin tests_failed++; $display("FAIL full_pp_drain: got %0d expected 0", occupancy); end
  endtask

  task automatic test_empty_pop;
    out_ready = 1'b1;
    drive(1'b0, 2'd1, 8'hFF);
    step(3);
    tests_run++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin tests_failed++; $display("FAIL empty_pop: got occ=%0d v=%b expected occ=0 v=0", occupancy, out_valid); end
    tests_run++; if (accepted_cnt !== 16'd10) begin tests_failed++; $display("FAIL accepted_so_far: got %0d expected 10", accepted_cnt); end
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    drive(1'b1, 2'd0, 8'hFF);
    step(2);
    tests_run++; if (occupancy !== 2'd2) begin tests_failed++; $display("FAIL rmid_fill: got %0d expected 2", occupancy); end
    drive(1'b1, 2'd3, 8'h00);
    rst = 1'b1;
    step();
    tests_run++; if (occupancy !== 2'd0 || out_valid !== 1'b0 || accepted_cnt !== 16'd0) begin tests_failed++; $display("FAIL rmid_clear: got occ=%0d v=%b cnt=%0d expected 0/0/0", occupancy, out_valid, accepted_cnt); end
    rst = 1'b0;
    drive(1'b0, 2'd0, 8'h00);
    out_ready = 1'b1;
    step(2);
    tests_run++; if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_result !== 2'b00) begin tests_failed++; $display("FAIL rmid_no_stale: got v=%b occ=%0d r=%b expected 0/0/00", out_valid, occupancy, out_result); end
  endtask

  task automatic test_saturation;
    out_ready = 1'b1;
    drive(1'b1, 2'd0, 8'h11);
    step(65534);
    tests_run++; if (accepted_cnt !== 16'hFFFE) begin tests_failed++; $display("FAIL sat_preload: got %h expected fffe", accepted_cnt); end
    step();
    tests_run++; if (accepted_cnt !== 16'hFFFF) begin tests_failed++; $display("FAIL sat_reach: got %h expected ffff", accepted_cnt); end
    step(2);
    drive(1'b0, 2'd0, 8'h00);
    tests_run++; if (accepted_cnt !== 16'hFFFF) begin tests_failed++; $display("FAIL sat_hold: got %h expected ffff", accepted_cnt); end
  endtask

  initial begin
    test_reset();
    test_or();
    test_modes();
    test_back_to_back();
    test_full_push_pop();
    test_empty_pop();
    test_reset_mid();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/vec_reduce_pipe.md
VEC_REDUCE_PIPE -- requirements
Module: vec_reduce_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 4, bits per channel operand (>=1).
REQ-002 SHALL have parameter NCHAN, default 2, independent channels per transaction (>=1).
REQ-003 SHALL have parameter DEPTH, default 2, result FIFO entries (power of two, >=2).
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port in_valid  input  1  request valid.
REQ-007 SHALL have port in_ready  output  1  request can be accepted.
REQ-008 SHALL have port in_mode  input  2  reduction op (reduce_mode_t).
REQ-009 SHALL have port in_data  input  NCHAN*WIDTH  channel c at bits [c*WIDTH +: WIDTH].
REQ-010 SHALL have port out_valid  output  1  FIFO head valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts head.
REQ-012 SHALL have port out_result  output  NCHAN  bit c = reduction of channel c.
REQ-013 SHALL have port out_mode  output  2  mode stored with head entry.
REQ-014 SHALL have port occupancy  output  $clog2(DEPTH)+1  entries held.
REQ-015 SHALL have port accepted_cnt  output  16  total accepted requests, saturating.

Function
REQ-016 SHALL compute per channel: mode 0 OR, 1 AND, 2 XOR, 3 NOR of that channel's WIDTH bits.
REQ-017 SHALL accept a request on a cycle where in_valid && in_ready, writing {mode, results} into FIFO tail at that edge.
REQ-018 SHALL present an accepted result on out_valid/out_result exactly 1 cycle after acceptance when FIFO was empty (no combinational in->out path).
REQ-019 SHALL drive in_ready = (occupancy < DEPTH) || out_ready-pop-this-cycle; i.e. when full, push allowed only together with pop.
REQ-020 SHALL pop head on out_valid && out_ready; out_valid = (occupancy != 0).
REQ-021 SHALL keep occupancy unchanged on simultaneous push and pop, including at full and at occupancy 1.
REQ-022 SHALL ignore out_ready while empty and in_valid while not in_ready (no state change).
REQ-023 SHALL wrap read/write pointers modulo DEPTH; results SHALL emerge strictly in acceptance order.
REQ-024 SHALL hold out_result/out_mode stable while out_valid && !out_ready.
REQ-025 SHALL increment accepted_cnt by 1 per acceptance, saturating at 16'hFFFF.

Reset
REQ-026 SHALL, on rst high at a clock edge, clear occupancy, pointers, accepted_cnt to 0; out_valid 0; out_result 0; out_mode 0.
REQ-027 SHALL drive in_ready 0 during reset cycles and 1 the first cycle after rst deasserts.
REQ-028 SHALL discard all stored entries and any same-cycle push when rst is asserted mid-operation.

Structure
REQ-029 SHALL place reduce_mode_t enum (RED_OR, RED_AND, RED_XOR, RED_NOR) and function reduce_chan(mode, operand) in package vec_reduce_pkg.
REQ-030 SHALL implement storage in one sub-module vec_reduce_fifo (parametrised by data width and DEPTH, same clk/rst).
REQ-031 SHALL be synthesisable with no latches and no DPI imports/exports.

Verification
REQ-032 Defaults, mode OR, in_data=8'h20, out_ready=1 -> next cycle out_valid=1, out_result=2'b10, out_mode=0.
REQ-033 Defaults, modes AND/XOR/NOR on in_data=8'hF7 -> out_result 2'b10, 2'b01, 2'b00 respectively, in order.
REQ-034 out_ready=0, push 3 requests back-to-back -> in_ready low after 2nd, occupancy=2, 3rd held; then out_ready=1 -> 3 results in order, occupancy returns to 0.
REQ-035 FIFO full, in_valid=1 and out_ready=1 same cycle -> push accepted, occupancy stays 2, head advances.
REQ-036 Preload accepted_cnt to 16'hFFFE via 65534 accepts, 3 more accepts -> accepted_cnt=16'hFFFF.
REQ-037 rst asserted with occupancy=2 and in_valid=1 -> next cycle occupancy=0, out_valid=0, accepted_cnt=0, no stale result after release.
